// File: rtl/mont_pkg.sv
// Shared definitions for the modular-exponentiation sequencer.
package mont_pkg;

    localparam int DEF_WIDTH  = 1024;
    localparam int DEF_ELEN_W = 11;

    // Each core operation is an issue state followed by its wait state.
    typedef enum logic [3:0] {
        IDLE,
        TOMONT,
        TOMONT_W,
        SQR,
        SQR_W,
        MUL,
        MUL_W,
        BITEND,
        FROMMONT,
        FROMMONT_W,
        DONE
    } montState_t;

endpackage

// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for an external Montgomery core.
// Converts the base into the Montgomery domain, walks the exponent from its
// most significant processed bit, and converts the accumulator back out.
module mont_modexp_ctrl
    import mont_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ELEN_W = DEF_ELEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  in_x,
    input  logic [WIDTH-1:0]  in_e,
    input  logic [ELEN_W-1:0] in_e_len,
    input  logic [WIDTH-1:0]  in_m,
    input  logic [WIDTH-1:0]  in_r2,
    input  logic [WIDTH-1:0]  in_rmodm,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              mont_resetn,
    output logic              mont_start,
    output logic [WIDTH-1:0]  mont_a,
    output logic [WIDTH-1:0]  mont_b,
    output logic [WIDTH-1:0]  mont_m,
    input  logic [WIDTH-1:0]  mont_result,
    input  logic              mont_done
);

    montState_t        state, nextState;
    logic [WIDTH-1:0]  xIn, r2Lat, xt, acc, eSh, resultReg, montMReg;
    logic [ELEN_W-1:0] bitCnt, eLenClamp, alignShift;

    // Exponent lengths beyond the operand width are clamped; the processed
    // bits are left-aligned so the next bit to consume is always the MSB.
    assign eLenClamp  = (in_e_len > ELEN_W'(WIDTH)) ? ELEN_W'(WIDTH) : in_e_len;
    assign alignShift = ELEN_W'(WIDTH) - eLenClamp;

    assign mont_resetn = ~reset;
    assign mont_m      = montMReg;
    assign result      = resultReg;
    assign busy        = (state != IDLE) && (state != DONE);
    assign done        = (state == DONE);

    // State register with synchronous abort on reset.
    // NOTE: clocked blocks use non-blocking assignments only, so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state decode and core operand mux; operands come from registers
    // that stay untouched from the issue cycle through mont_done.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        nextState  = state;
        mont_start = 1'b0;
        mont_a     = '0;
        mont_b     = '0;
        unique case (state)
            IDLE: begin
                if (start) nextState = TOMONT;
            end
            TOMONT, TOMONT_W: begin
                mont_start = (state == TOMONT);
                mont_a     = xIn;
                mont_b     = r2Lat;
                if (state == TOMONT) nextState = TOMONT_W;
                else if (mont_done)  nextState = (bitCnt != '0) ? SQR : FROMMONT;
            end
            SQR, SQR_W: begin
                mont_start = (state == SQR);
                mont_a     = acc;
                mont_b     = acc;
                if (state == SQR)   nextState = SQR_W;
                else if (mont_done) nextState = eSh[WIDTH-1] ? MUL : BITEND;
            end
            MUL, MUL_W: begin
                mont_start = (state == MUL);
                mont_a     = acc;
                mont_b     = xt;
                if (state == MUL)   nextState = MUL_W;
                else if (mont_done) nextState = BITEND;
            end
            BITEND: begin
                nextState = (bitCnt != ELEN_W'(1)) ? SQR : FROMMONT;
            end
            FROMMONT, FROMMONT_W: begin
                mont_start = (state == FROMMONT);
                mont_a     = acc;
                mont_b     = WIDTH'(1);
                if (state == FROMMONT) nextState = FROMMONT_W;
                else if (mont_done)    nextState = DONE;
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Operand latching on accept and destination loads on core completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            xIn       <= '0;
            r2Lat     <= '0;
            montMReg  <= '0;
            xt        <= '0;
            acc       <= '0;
            eSh       <= '0;
            bitCnt    <= '0;
            resultReg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        xIn      <= in_x;
                        r2Lat    <= in_r2;
                        montMReg <= in_m;
                        acc      <= in_rmodm;
                        eSh      <= in_e << alignShift;
                        bitCnt   <= eLenClamp;
                    end
                end
                TOMONT_W: begin
                    if (mont_done) xt <= mont_result;
                end
                SQR_W, MUL_W: begin
                    if (mont_done) acc <= mont_result;
                end
                BITEND: begin
                    eSh    <= eSh << 1;
                    bitCnt <= bitCnt - ELEN_W'(1);
                end
                FROMMONT_W: begin
                    if (mont_done) resultReg <= mont_result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Scoreboard bench for mont_modexp_ctrl with a behavioural Montgomery core
// (a*b*R^-1 mod M, fixed latency) at WIDTH=8, M=13.
module tb_mont_modexp_ctrl;

    localparam int W   = 8;
    localparam int EW  = 4;
    localparam int LAT = 5;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [W-1:0]  in_x, in_e, in_m, in_r2, in_rmodm;
    logic [EW-1:0] in_e_len;
    logic          busy, done, mont_resetn, mont_start;
    logic [W-1:0]  result, mont_a, mont_b, mont_m;
    logic [W-1:0]  mont_result = '0;
    logic          mont_done = 1'b0;

    mont_modexp_ctrl #(.WIDTH(W), .ELEN_W(EW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_x(in_x), .in_e(in_e), .in_e_len(in_e_len), .in_m(in_m),
        .in_r2(in_r2), .in_rmodm(in_rmodm),
        .busy(busy), .done(done), .result(result),
        .mont_resetn(mont_resetn), .mont_start(mont_start),
        .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
        .mont_result(mont_result), .mont_done(mont_done)
    );

    always #5 clk = ~clk;

    int passCnt  = 0;
    int totalCnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Behavioural Montgomery product a*b*R^-1 mod m with R = 2^W.
    function automatic logic [W-1:0] montMul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
        longint r, rInv;
        rInv = 0;
        for (int k = 1; k < int'(m); k++)
            if (((longint'(1) << W) * k) % m == 1) rInv = k;
        r = (longint'(a) * longint'(b)) % m;
        r = (r * rInv) % m;
        return W'(r);
    endfunction

    // Core model: captures operands on mont_start, answers LAT cycles later.
    int           coreCnt = 0;
    logic [W-1:0] capA = '0, capB = '0, capM = '0, pendRes = '0;
    always @(posedge clk) begin
        if (!mont_resetn) begin
            coreCnt     <= 0;
            mont_done   <= 1'b0;
            mont_result <= 8'hA5;
        end else begin
            mont_done   <= 1'b0;
            mont_result <= 8'hA5;
            if (mont_start) begin
                capA    <= mont_a;
                capB    <= mont_b;
                capM    <= mont_m;
                pendRes <= montMul(mont_a, mont_b, mont_m);
                coreCnt <= LAT;
            end else if (coreCnt != 0) begin
                coreCnt <= coreCnt - 1;
                if (coreCnt == 1) begin
                    mont_done   <= 1'b1;
                    mont_result <= pendRes;
                end
            end
        end
    end

    typedef struct {
        logic [W-1:0] res;
        int           ops;
    } expT;
    expT sbQ[$];

    // Monitor: counts core ops, checks operand stability and pops the scoreboard on done.
    int   opCnt    = 0;
    logic prevBusy = 1'b0;
    always @(negedge clk) begin
        expT e;
        if (reset) begin
            opCnt = 0;
        end else begin
            if (mont_start) opCnt++;
            if (mont_done)
                check("operands_stable", {8'h0, mont_a, mont_b, mont_m}, {8'h0, capA, capB, capM});
            if (done) begin
                check("sb_pending", sbQ.size(), 1);
                if (sbQ.size() != 0) begin
                    e = sbQ.pop_front();
                    check("result", result, e.res);
                    check("core_ops", opCnt, e.ops);
                    check("busy_low_at_done", busy, 0);
                    check("busy_high_before_done", prevBusy, 1);
                end
                opCnt = 0;
            end
        end
        prevBusy = busy;
    end

    task automatic startOp(input logic [W-1:0] x, input logic [W-1:0] e, input logic [EW-1:0] len,
                           input bit push, input logic [W-1:0] expRes, input int expOps);
        expT ent;
        @(negedge clk);
        in_x = x; in_e = e; in_e_len = len; start = 1'b1;
        if (push) begin
            ent.res = expRes;
            ent.ops = expOps;
            sbQ.push_back(ent);
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic waitDone(input logic [W-1:0] expRes);
        bit seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("done_seen", seen, 1);
        @(negedge clk);
        check("done_single_pulse", done, 0);
        check("result_hold", result, expRes);
    endtask

    task automatic runOp(input logic [W-1:0] x, input logic [W-1:0] e, input logic [EW-1:0] len,
                         input logic [W-1:0] expRes, input int expOps);
        startOp(x, e, len, 1, expRes, expOps);
        waitDone(expRes);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0;
        in_x = '0; in_e = '0; in_e_len = '0;
        in_m = 8'd13; in_r2 = 8'd3; in_rmodm = 8'd9;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_mont_start", mont_start, 0);
        check("rst_mont_resetn", mont_resetn, 0);
        reset = 1'b0;
        @(negedge clk);
        check("mont_resetn_released", mont_resetn, 1);

        runOp(8'd5,   8'd3,   4'd2,  8'd8,  6);   // 5^3 mod 13
        runOp(8'd5,   8'd3,   4'd4,  8'd8,  8);   // leading zero bits
        runOp(8'd5,   8'd0,   4'd0,  8'd1,  2);   // empty exponent
        runOp(8'd5,   8'd0,   4'd8,  8'd1,  10);  // all-zero exponent
        runOp(8'd12,  8'd255, 4'd8,  8'd12, 18);  // (-1)^255
        runOp(8'd5,   8'd3,   4'd15, 8'd8,  12);  // length clamped to 8

        // Second start while busy must be ignored.
        startOp(8'd5, 8'd3, 4'd2, 1, 8'd8, 6);
        repeat (10) @(negedge clk);
        startOp(8'd2, 8'd5, 4'd3, 0, 8'd0, 0);
        waitDone(8'd8);
        repeat (20) @(negedge clk);
        check("result_unchanged", result, 8'd8);
        runOp(8'd2, 8'd5, 4'd3, 8'd6, 7);         // 2^5 mod 13

        // Abort in MUL_W: third core op of 5^3 is the first MUL.
        startOp(8'd5, 8'd3, 4'd2, 0, 8'd0, 0);
        n = 0;
        for (int i = 0; i < 500; i++) begin
            if (mont_start) n++;
            if (n == 3) break;
            @(negedge clk);
        end
        check("reached_mul", n, 3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_mont_resetn", mont_resetn, 0);
        check("abort_mont_start", mont_start, 0);
        reset = 1'b0;
        @(negedge clk);
        runOp(8'd5, 8'd3, 4'd2, 8'd8, 6);

        repeat (5) @(negedge clk);
        check("sb_drained", sbQ.size(), 0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/mont_modexp_ctrl.md
Name: mont_modexp_ctrl

Overview:
- Sequencer that computes X^E mod M by scheduling a single external Montgomery multiplier core (interface: start, a, b, m, result, done).
- Uses left-to-right square-and-multiply.
- Sits between the RSA top level and the Montgomery core. It owns the core's operand muxing, start pulses and reset, and it latches each core result.

Parameters:
- WIDTH, 1024, operand/modulus width in bits; R = 2^WIDTH.
- ELEN_W, 11, width of the exponent-length field (must hold the value WIDTH).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- in_x  in  WIDTH  base, require in_x < in_m
- in_e  in  WIDTH  exponent
- in_e_len  in  ELEN_W  number of exponent bits to process, 0..WIDTH
- in_m  in  WIDTH  odd modulus
- in_r2  in  WIDTH  R^2 mod M
- in_rmodm  in  WIDTH  R mod M (Montgomery one)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; result valid
- result  out  WIDTH  X^E mod M; holds until the next accepted start
- mont_resetn  out  1  core reset, equal to ~reset
- mont_start  out  1  one-cycle core start
- mont_a  out  WIDTH  core operand A
- mont_b  out  WIDTH  core operand B
- mont_m  out  WIDTH  core modulus, registered copy of in_m
- mont_result  in  WIDTH  core result; valid only in the mont_done cycle
- mont_done  in  1  core completion pulse

Behaviour:
- Reset: state IDLE; busy=0, done=0, mont_start=0, result=0; internal regs (xt, acc, e_sh, bit_cnt) cleared.
- Reset mid-operation: abort immediately. Because mont_resetn follows ~reset, the core is reset in the same cycle.
- IDLE + start:
  - Latch in_x, in_e, in_m, in_r2.
  - acc <= in_rmodm; e_sh <= in_e << (WIDTH - in_e_len); bit_cnt <= in_e_len.
  - Go to TOMONT.
- Every compute step is an issue state followed by a wait state:
  - Issue state (mont_start=1 for exactly one cycle) with the operands registered. Next cycle is the wait state.
  - mont_a, mont_b and mont_m are held stable from the issue cycle through mont_done.
  - In the wait state, on mont_done the destination register is loaded with mont_result and the FSM moves to the next issue state on the following cycle.
  - mont_done outside a wait state is ignored.
- Step sequence:
  - TOMONT: a = in_x, b = r2; on done, xt <= result. Next: SQR if bit_cnt != 0, else FROMMONT.
  - SQR: a = acc, b = acc; on done, acc <= result. Next: MUL if e_sh[WIDTH-1] == 1, else BITEND.
  - MUL: a = acc, b = xt; on done, acc <= result. Next: BITEND.
  - BITEND (1 cycle, no core op): e_sh <<= 1; bit_cnt -= 1. Next: SQR if the new bit_cnt != 0, else FROMMONT.
  - FROMMONT: a = acc, b = 1; on done, result <= mont_result. Next: DONE.
  - DONE: done = 1 for one cycle, then IDLE.
- start while busy is ignored.
- in_e_len = 0, or in_e = 0: result = 1 mod M, from 2 core ops.
- in_e_len > WIDTH is clamped to WIDTH.
- Number of core ops = 2 + e_len + popcount(processed bits).
- Latency = sum over ops of (1 issue cycle + core latency) + e_len BITEND cycles + 1 DONE cycle.
- The FSM has no internal timeout; it hangs if the core never asserts mont_done.

Decomposition:
- Shared package mont_pkg:
  - State enum: IDLE, TOMONT, TOMONT_W, SQR, SQR_W, MUL, MUL_W, BITEND, FROMMONT, FROMMONT_W, DONE.
  - Default WIDTH / ELEN_W constants.
- No sub-module inside the controller. The multiplier core is instantiated beside it at the top level.
- For unit test, a behavioural core model is used: a*b*R^-1 mod M with a programmable latency of 5 cycles.

Test Plan:
- WIDTH=8, M=13, r2=3, rmodm=9, X=5, E=3, e_len=2 -> result=8; exactly 6 mont_start pulses; done pulses once; busy drops the same cycle done rises.
- Same setup with e_len=4, E=0b0011 (leading zeros) -> result=8; 8 mont_start pulses (4 SQR, 2 MUL).
- E=0 with e_len=0, then E=0 with e_len=8 -> result=1 in both cases; 2 core ops and 10 core ops respectively.
- X=12, E=255, e_len=8, M=13 -> result=12 (12 = -1 mod 13, odd exponent); 18 core ops. The operands are checked to be stable through each mont_done.
- start pulsed again while busy -> ignored; result unchanged. A later IDLE start with X=2, E=5, e_len=3 -> result=6.
- reset asserted while in MUL_W -> next cycle: IDLE, busy=0, result=0, mont_resetn=0. A fresh start after reset completes correctly.
